// File: rtl/exec_wb_unit.sv
// Execute/write-back stage: ALU ops, shift-add multiply, GPR write-back.
// Define EXEC_FORWARD_EN to accept issue during WB with a result bypass.
module exec_wb_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [2:0] opcode,
  input  logic [2:0] rd,
  input  logic [2:0] rs1,
  input  logic [2:0] rs2,
  output logic [2:0] reg_read_addr_1,
  output logic [2:0] reg_read_addr_2,
  input  logic [7:0] reg_read_data_1,
  input  logic [7:0] reg_read_data_2,
  output logic       reg_write_en,
  output logic [2:0] reg_write_dest,
  output logic [7:0] reg_write_data,
  output logic       flag_zero,
  output logic       flag_carry,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [2:0]  rd_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] mcand;
  logic [15:0] acc;
  logic [15:0] acc_next;
  logic [7:0]  bit_cnt;
  logic        carry_q;
  logic [7:0]  opnd_1;
  logic [7:0]  opnd_2;
  logic        fire;
  logic [8:0]  alu_sum;
  logic [7:0]  alu_res;
  logic        alu_c;

  assign reg_read_addr_1 = rs1;
  assign reg_read_addr_2 = rs2;
  assign busy = (state != IDLE);
  assign fire = issue_valid && issue_ready;

`ifdef EXEC_FORWARD_EN
  // The GPR still holds the old value while WB is writing it.
  assign issue_ready = (state == IDLE) || (state == WB);
  assign opnd_1 = (state == WB && rs1 == reg_write_dest)
                  ? reg_write_data : reg_read_data_1;
  assign opnd_2 = (state == WB && rs2 == reg_write_dest)
                  ? reg_write_data : reg_read_data_2;
`else
  assign issue_ready = (state == IDLE);
  assign opnd_1 = reg_read_data_1;
  assign opnd_2 = reg_read_data_2;
`endif

  always_comb begin
    alu_sum = 9'd0;
    alu_res = 8'd0;
    alu_c   = 1'b0;
    case (op_q)
      3'b000: begin
        alu_sum = {1'b0, a_q} + {1'b0, b_q};
        alu_res = alu_sum[7:0];
        alu_c   = alu_sum[8];
      end
      3'b001: begin
        alu_sum = {1'b0, a_q} - {1'b0, b_q};
        alu_res = alu_sum[7:0];
        alu_c   = alu_sum[8];
      end
      3'b010: alu_res = a_q & b_q;
      3'b011: alu_res = a_q | b_q;
      3'b100: alu_res = a_q ^ b_q;
      3'b101: begin
        alu_res = {a_q[6:0], 1'b0};
        alu_c   = a_q[7];
      end
      3'b110: alu_res = b_q;
      default: alu_res = 8'd0;
    endcase
  end

  assign acc_next = b_q[0] ? acc + mcand : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      reg_write_en   <= 1'b0;
      reg_write_dest <= 3'd0;
      reg_write_data <= 8'd0;
      flag_zero      <= 1'b0;
      flag_carry     <= 1'b0;
      op_q           <= 3'd0;
      rd_q           <= 3'd0;
      a_q            <= 8'd0;
      b_q            <= 8'd0;
      mcand          <= 16'd0;
      acc            <= 16'd0;
      bit_cnt        <= 8'd0;
      carry_q        <= 1'b0;
    end else begin
      reg_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (fire)
            state <= (opcode == 3'b111) ? MUL : EXEC;
        end
        EXEC: begin
          reg_write_data <= alu_res;
          reg_write_dest <= rd_q;
          carry_q        <= alu_c;
          reg_write_en   <= 1'b1;
          state          <= WB;
        end
        MUL: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          b_q     <= b_q >> 1;
          bit_cnt <= bit_cnt + 8'd1;
          if (bit_cnt == 8'd7) begin
            reg_write_data <= acc_next[7:0];
            reg_write_dest <= rd_q;
            carry_q        <= (acc_next[15:8] != 8'd0);
            reg_write_en   <= 1'b1;
            state          <= WB;
          end
        end
        default: begin
          flag_zero  <= (reg_write_data == 8'd0);
          flag_carry <= carry_q;
          if (fire)
            state <= (opcode == 3'b111) ? MUL : EXEC;
          else
            state <= IDLE;
        end
      endcase
      if (fire) begin
        op_q    <= opcode;
        rd_q    <= rd;
        a_q     <= opnd_1;
        b_q     <= opnd_2;
        mcand   <= {8'd0, opnd_1};
        acc     <= 16'd0;
        bit_cnt <= 8'd0;
      end
    end
  end

endmodule
